// File: rtl/ecg_pkg.sv
// rtl/ecg_pkg.sv - shared ECG beat constants, window feeder state enum and window-count helper
package ecg_pkg;

  localparam int DATA_W    = 32;
  localparam int N_SAMPLES = 187;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    OUT
  } win_state_t;

  // Windows per beat: one per padded position with "same" padding, else only fully-populated ones.
  function automatic int win_count(input int n, input int k, input bit pad);
    return pad ? n : n - k + 1;
  endfunction

endpackage

// File: rtl/ecg_window_feeder.sv
// rtl/ecg_window_feeder.sv - stride-1 KERNEL-sample window streamer over the input ROM read port
// ECG_WIN_PAD_EN selects "same" zero padding of (KERNEL-1)/2 samples on each side.
module ecg_window_feeder #(
  parameter int DATA_W    = ecg_pkg::DATA_W,
  parameter int N_SAMPLES = ecg_pkg::N_SAMPLES,
  parameter int KERNEL    = 5,
  parameter int ADDR_W    = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  output logic [ADDR_W-1:0]        o_sample_addr,
  input  logic [DATA_W-1:0]        i_sample_data,
  output logic                     o_win_valid,
  input  logic                     i_win_ready,
  output logic [KERNEL*DATA_W-1:0] o_win_data,
  output logic [ADDR_W-1:0]        o_win_idx,
  output logic                     o_busy,
  output logic                     o_done
);
  import ecg_pkg::*;

`ifdef ECG_WIN_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int PAD    = PAD_EN ? (KERNEL - 1) / 2 : 0;
  localparam int N_WIN  = win_count(N_SAMPLES, KERNEL, PAD_EN);
  localparam int POS_W  = ADDR_W + 1;
  localparam int FILL_W = $clog2(KERNEL);
  localparam int WIN_W  = KERNEL * DATA_W;

  localparam logic [POS_W-1:0]  PAD_P    = POS_W'(PAD);
  localparam logic [POS_W-1:0]  N_LIM    = POS_W'(N_SAMPLES);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_WIN - 1);
  localparam logic [FILL_W-1:0] FULL     = FILL_W'(KERNEL - 1);

  win_state_t         r_state;
  win_state_t         w_next_state;
  logic [POS_W-1:0]   r_pos;
  logic [FILL_W-1:0]  r_fill;
  logic [ADDR_W-1:0]  r_idx;
  logic [WIN_W-1:0]   r_win;
  logic               r_done;

  logic               w_accept;
  logic               w_hs;
  logic               w_last;
  logic               w_in_range;
  logic [POS_W-1:0]   w_src;
  logic [DATA_W-1:0]  w_load;

  // Leading pad positions wrap to large unsigned values, so one compare covers both edges.
  assign w_src      = r_pos - PAD_P;
  assign w_in_range = (w_src < N_LIM);
  assign w_load     = w_in_range ? i_sample_data : '0;

  assign w_accept = (r_state == IDLE) && i_start && !r_done;
  assign w_hs     = (r_state == OUT) && i_win_ready;
  assign w_last   = (r_idx == LAST_IDX);

  assign o_sample_addr = w_in_range ? w_src[ADDR_W-1:0] : '0;
  assign o_win_data    = r_win;
  assign o_win_idx     = r_idx;
  assign o_done        = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_win_valid  = 1'b0;
    o_busy       = 1'b1;
    unique case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (w_accept) w_next_state = FETCH;
      end
      FETCH: w_next_state = LOAD;
      LOAD:  w_next_state = (r_fill == FULL) ? OUT : FETCH;
      OUT: begin
        o_win_valid = 1'b1;
        if (i_win_ready) w_next_state = w_last ? IDLE : FETCH;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pos  <= '0;
      r_fill <= '0;
      r_idx  <= '0;
      r_win  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_pos  <= '0;
        r_fill <= '0;
        r_idx  <= '0;
      end
      if (r_state == LOAD) begin
        // Newest sample enters the top slice; slice 0 always holds the oldest.
        r_win <= {w_load, r_win[WIN_W-1:DATA_W]};
        r_pos <= r_pos + 1'b1;
        if (r_fill != FULL) r_fill <= r_fill + 1'b1;
      end
      if (w_hs) begin
        if (w_last) r_done <= 1'b1;
        else        r_idx  <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecg_window_feeder.sv
// tb/tb_ecg_window_feeder.sv - scoreboard bench for ecg_window_feeder against a random ROM image
`timescale 1ns/1ps
module tb_ecg_window_feeder;

  localparam int DW  = 32;
  localparam int N   = 187;
  localparam int K   = 5;
  localparam int AW  = 8;
  localparam int KDW = K * DW;
`ifdef ECG_WIN_PAD_EN
  localparam int P  = (K - 1) / 2;
  localparam int NW = N;
`else
  localparam int P  = 0;
  localparam int NW = N - K + 1;
`endif
  localparam int DUR = 2 * K + 3 * (NW - 1) + 1;

  logic           clk   = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           ready = 1'b0;
  logic [AW-1:0]  addr;
  logic [AW-1:0]  idx;
  logic [DW-1:0]  rom_q = '0;
  logic           valid;
  logic           busy;
  logic           done;
  logic [KDW-1:0] wdata;

  logic [DW-1:0] rom [N];

  typedef struct {
    logic [KDW-1:0] data;
    logic [AW-1:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   ready_mode = 0;
  int   stall_left = 0;
  bit   prev_stall = 1'b0;
  logic [KDW-1:0] prev_data;
  logic [AW-1:0]  prev_idx;
  logic [AW-1:0]  prev_addr;

  ecg_window_feeder #(
    .DATA_W(DW), .N_SAMPLES(N), .KERNEL(K), .ADDR_W(AW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .o_sample_addr(addr),
    .i_sample_data(rom_q),
    .o_win_valid(valid),
    .i_win_ready(ready),
    .o_win_data(wdata),
    .o_win_idx(idx),
    .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  // One-cycle registered ROM read port.
  always @(posedge clk) rom_q <= (int'(addr) < N) ? rom[addr] : 32'hdead_beef;

  task automatic check(input string name, input logic [KDW-1:0] act, input logic [KDW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Window i covers padded positions i..i+K-1; position p is sample p-P or zero outside the beat.
  function automatic logic [KDW-1:0] model_win(input int i);
    logic [KDW-1:0] v;
    v = '0;
    for (int j = 0; j < K; j++) begin
      int s;
      s = i + j - P;
      if (s >= 0 && s < N) v[j*DW +: DW] = rom[s];
    end
    return v;
  endfunction

  task automatic push_beat();
    exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.data = model_win(i);
      e.idx  = AW'(i);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, KDW'(done), KDW'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, KDW'(valid), '0);
    check({tag, "_busy"},  KDW'(busy),  '0);
    check({tag, "_done"},  KDW'(done),  '0);
    check({tag, "_addr"},  KDW'(addr),  '0);
    check({tag, "_idx"},   KDW'(idx),   '0);
    check({tag, "_data"},  wdata,       '0);
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (ready_mode == 0) begin
      ready = 1'b1;
    end else if (valid && idx == AW'(3) && stall_left > 0) begin
      ready = 1'b0;
      stall_left--;
    end else begin
      ready = 1'($urandom_range(0, 1));
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && prev_stall) begin
        check("hold_data", wdata, prev_data);
        check("hold_idx", KDW'(idx), KDW'(prev_idx));
        check("hold_addr", KDW'(addr), KDW'(prev_addr));
      end
      prev_stall = valid && !ready;
      prev_data  = wdata;
      prev_idx   = idx;
      prev_addr  = addr;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_window: got idx %0d expected no window", idx);
        end else begin
          mon_e = exp_q.pop_front();
          check("win_data", wdata, mon_e.data);
          check("win_idx", KDW'(idx), KDW'(mon_e.idx));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", KDW'(exp_q.size()), '0);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    int n;
    int first;
    int dc;
    for (int i = 0; i < N; i++) rom[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Beat 1: ready held high throughout, latency and beat length.
    ready_mode = 0;
    pulse_start();
    push_beat();
    check("start_busy", KDW'(busy), KDW'(1));
    n = 0;
    first = -1;
    while (!done && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
      if (valid && first < 0) first = n;
    end
    check("first_valid_latency", KDW'(first), KDW'(2 * K));
    check("beat_cycles", KDW'(n), KDW'(DUR));
    check("busy_in_done_cycle", KDW'(busy), '0);
    // START during the DONE cycle must be ignored.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("done_cycle_start_busy", KDW'(busy), '0);
    check("done_cycle_start_valid", KDW'(valid), '0);
    check("done_one_cycle", KDW'(done), '0);

    // Beat 2: random backpressure, long stall on window 3, START while busy.
    ready_mode = 1;
    stall_left = 10;
    pulse_start();
    push_beat();
    check("start2_busy", KDW'(busy), KDW'(1));
    repeat (150) @(posedge clk);
    pulse_start();
    wait_done("beat2_done", 8000);
    repeat (3) @(posedge clk);

    // Beat 3: reset in the middle of window 50.
    ready_mode = 0;
    pulse_start();
    push_beat();
    n = 0;
    while (!(valid && idx == AW'(50)) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reach_window_50", KDW'(valid && idx == AW'(50)), KDW'(1));
    dc = done_cnt;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midbeat_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("no_done_on_reset", KDW'(done_cnt), KDW'(dc));
    @(negedge clk);
    rst_n = 1'b1;

    // Beat 4: clean restart after reset.
    pulse_start();
    push_beat();
    wait_done("beat4_done", 4000);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", KDW'(done_cnt), KDW'(3));
    check("queue_drained", KDW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
